// File: rtl/irq_pending_latch.sv
// irq_pending_latch
// -----------------------------------------------------------------------------
// Front end of the 4-to-2 priority encoder.
//
// Each asynchronous request line first passes through a synchroniser chain.
// An event is then detected on the line, either as a rising edge or as a
// level. Each event is held in a sticky pending bit, which drives encoder
// input D0..D3. The consumer clears a pending bit by acknowledging its index.
// If an event arrives while its line is still pending and is not being
// cleared in that cycle, the event is recorded in a per-line overflow flag.
//
// Parameters
//   SYNC_STAGES : flops per request line in the synchroniser (legal 1..4)
//   EDGE_MODE   : 1 = pending set on rising edge of synchronised request,
//                 0 = pending set while synchronised request is high
//
// Ports
//   clk        in   single clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   asynchronous request lines
//   mask[3:0]  in   per-line enable for setting pending
//   ack_valid  in   consumer acknowledges one line this cycle
//   ack_idx    in   index of the acknowledged line
//   ovf_clr    in   clears all overflow flags
//   D0..D3     out  registered pending bits to the encoder
//   any_pend   out  OR of the pending bits
//   ovf[3:0]   out  sticky per-line overflow flags
// -----------------------------------------------------------------------------
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       ack_valid,
    input  logic [1:0] ack_idx,
    input  logic       ovf_clr,
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       any_pend,
    output logic [3:0] ovf
);

    // Synchroniser stages, with all four lines packed into each stage.
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_s;
    logic [3:0] hist_q;
    logic [3:0] pend_q;
    logic [3:0] ovf_q;
    logic [3:0] ev;
    logic [3:0] set;
    logic [3:0] clr;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The synchroniser chain and the edge history keep running while a line
    // is masked. As a result, unmasking a line that is already high does not
    // look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_s;
        end
    end

    // Edge mode fires only in the first cycle a synchronised line is seen
    // high. Because the history resets to 0, a request held high through
    // reset produces exactly one event after reset exits.
    always_comb begin
        if (EDGE_MODE) begin
            ev = sync_s & ~hist_q;
        end else begin
            ev = sync_s;
        end
        set = ev & mask;
    end

    // Decode the acknowledge into a one-hot clear vector.
    always_comb begin
        clr = '0;
        if (ack_valid) begin
            clr[ack_idx] = 1'b1;
        end
    end

    // Set has priority over clear, so an event that coincides with the
    // acknowledge of the same line is kept. An overflow is recorded only when
    // the new event lands on a bit that is still pending after this cycle's
    // clear. A new overflow also beats a simultaneous ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= set | (pend_q & ~clr);
            ovf_q  <= (ovf_q & ~{4{ovf_clr}}) | (set & pend_q & ~clr);
        end
    end

    assign D0       = pend_q[0];
    assign D1       = pend_q[1];
    assign D2       = pend_q[2];
    assign D3       = pend_q[3];
    assign any_pend = |pend_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch
// -----------------------------------------------------------------------------
// Directed-vector bench for irq_pending_latch with the default parameters
// (SYNC_STAGES = 2, EDGE_MODE = 1). Expected values are hand-computed.
// A request sampled at edge n appears on D at edge n+2.
// -----------------------------------------------------------------------------
module tb_irq_pending_latch;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack_valid;
    logic [1:0] ack_idx;
    logic       ovf_clr;
    logic       D0;
    logic       D1;
    logic       D2;
    logic       D3;
    logic       any_pend;
    logic [3:0] ovf;
    logic [3:0] dvec;

    int total;
    int bad;

    irq_pending_latch dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .ovf_clr   (ovf_clr),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .any_pend  (any_pend),
        .ovf       (ovf)
    );

    assign dvec = {D3, D2, D1, D0};

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [3:0] mk, input logic av,
                                 input logic [1:0] ai, input logic oc);
        rst       = r;
        req       = rq;
        mask      = mk;
        ack_valid = av;
        ack_idx   = ai;
        ovf_clr   = oc;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [3:0] got,
                               input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = '0;
        mask      = '0;
        ack_valid = 1'b0;
        ack_idx   = '0;
        ovf_clr   = 1'b0;

        // 1. Reset with all requests held high
        applyStimulus(1, 4'hF, 4'hF, 0, 0, 0);
        applyStimulus(1, 4'hF, 4'hF, 0, 0, 0);
        checkOutput("rst_d", dvec, 4'h0);
        checkOutput("rst_ovf", ovf, 4'h0);
        checkOutput("rst_any", {3'b0, any_pend}, 4'h0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0, 0);
        checkOutput("rel_e1", dvec, 4'h0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0, 0);
        checkOutput("rel_e2", dvec, 4'h0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0, 0);
        checkOutput("rel_e3", dvec, 4'hF);
        checkOutput("rel_any", {3'b0, any_pend}, 4'h1);
        applyStimulus(0, 4'hF, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0, 0);
        checkOutput("held_d", dvec, 4'hF);
        checkOutput("held_ovf", ovf, 4'h0);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(0, 4'hF, 4'hF, 1, 2'(i), 0);
        end
        checkOutput("held_clr", dvec, 4'h0);

        // 2. Single one-cycle pulse on line 2
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("fall_noev", dvec, 4'h0);
        applyStimulus(0, 4'b0100, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("p2_early", dvec, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("p2_set", dvec, 4'b0100);
        checkOutput("p2_any", {3'b0, any_pend}, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 1, 2, 0);
        checkOutput("p2_ack", dvec, 4'h0);
        checkOutput("p2_any0", {3'b0, any_pend}, 4'h0);

        // 3. Simultaneous events, then acknowledges in encoder order
        applyStimulus(0, 4'b1010, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'b1010, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'b1010, 4'hF, 0, 0, 0);
        checkOutput("m_set", dvec, 4'b1010);
        applyStimulus(0, 4'b1010, 4'hF, 1, 3, 0);
        checkOutput("m_ack3", dvec, 4'b0010);
        applyStimulus(0, 4'b1010, 4'hF, 1, 1, 0);
        checkOutput("m_ack1", dvec, 4'b0000);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("m_idle", dvec, 4'h0);

        // 4. Set/clear collision and overflow handling on line 0
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("c_set", dvec, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
        checkOutput("c_coll_d", dvec, 4'h1);
        checkOutput("c_coll_ovf", ovf, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("c_ovf", ovf, 4'h1);
        checkOutput("c_ovf_d", dvec, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 1);
        checkOutput("c_ovfclr", ovf, 4'h0);
        checkOutput("c_ovfclr_d", dvec, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 1);
        checkOutput("c_setwins", ovf, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 1);
        checkOutput("c_ovfclr2", ovf, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
        checkOutput("c_ack0", dvec, 4'h0);

        // 5. Masking and unmasking a held request
        applyStimulus(0, 4'h1, 4'hE, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hE, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hE, 0, 0, 0);
        checkOutput("k_masked", dvec, 4'h0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        checkOutput("k_unmask", dvec, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        checkOutput("k_fresh_e", dvec, 4'h0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        checkOutput("k_fresh", dvec, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 1, 0, 0);
        checkOutput("k_ack", dvec, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);

        // 6. Reset in mid-operation, then an acknowledge of an idle line
        applyStimulus(0, 4'b1011, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("r_set", dvec, 4'b1011);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("r_pre_d", dvec, 4'b1011);
        checkOutput("r_pre_ovf", ovf, 4'h1);
        applyStimulus(1, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("r_d", dvec, 4'h0);
        checkOutput("r_ovf", ovf, 4'h0);
        checkOutput("r_any", {3'b0, any_pend}, 4'h0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        checkOutput("s_set", dvec, 4'h1);
        applyStimulus(0, 4'h0, 4'hF, 1, 2, 0);
        checkOutput("s_stray_d", dvec, 4'h1);
        checkOutput("s_stray_ovf", ovf, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 4-to-2 priority encoder.
- Synchronises four asynchronous request lines and detects events on them, either rising edges or levels.
- Holds each event as a sticky pending bit, which drives the encoder inputs D0..D3.
- The consumer, after acting on the encoded index Y, clears the corresponding bit through an acknowledge handshake. Lost/duplicate events are flagged per line.

Parameters:
- SYNC_STAGES, 2, flops per request line in the synchroniser chain; legal range 1..4.
- EDGE_MODE, 1, 1 = pending set on rising edge of synchronised request; 0 = pending set while synchronised request is high (level).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  asynchronous request lines, bit i = line i
- mask  input  4  synchronous enable, 1 = line i may set pending
- ack_valid  input  1  consumer acknowledges one line this cycle
- ack_idx  input  2  index of line being acknowledged (normally the encoder Y)
- ovf_clr  input  1  clears all overflow flags
- D0  output  1  pending bit line 0 (to encoder D0)
- D1  output  1  pending bit line 1
- D2  output  1  pending bit line 2
- D3  output  1  pending bit line 3
- any_pend  output  1  OR of D3..D0
- ovf  output  4  sticky per-line overflow flags

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All registers update only on the rising edge of clk.
- Reset: synchroniser chain, edge-history register, pending bits, and ovf all go to 0. Therefore D0..D3 = 0, any_pend = 0, ovf = 4'b0000 on the cycle after rst is sampled high.
- Reset wins over every other input in the same cycle.
- Synchroniser: per line, SYNC_STAGES flops in series; s_i is the last stage. Edge history h_i is one further flop fed from s_i.
- Event detection, line i:
  - EDGE_MODE=1: ev_i = s_i & ~h_i.
  - EDGE_MODE=0: ev_i = s_i.
- Set condition: set_i = ev_i & mask[i].
- Latency: req[i] rises and is first sampled at edge n. With EDGE_MODE=1, D_i is high after edge n+SYNC_STAGES. Default is 2 cycles.
- Because h resets to 0, a request held high through reset produces one event after reset exits.
- Acknowledge: clr_i = ack_valid & (ack_idx == i). Only one line can be cleared per cycle.
- Pending update per line: next_D_i = set_i | (D_i & ~clr_i). Set and clear on the same line in the same cycle leaves the bit at 1 (new event not lost).
- Ack of a non-pending line: no effect, no error flag.
- Mask: gates set only. Pending bits already set remain until acknowledged. Synchroniser and h keep tracking while masked, so unmasking does not create a spurious edge from history.
- Overflow:
  - ovf[i] set when set_i & D_i & ~clr_i, i.e. a new event arrives while the bit is already pending and not being cleared this cycle.
  - Sticky until ovf_clr = 1. If ovf_clr and a new overflow coincide, the set wins.
  - In EDGE_MODE=0 a held level re-asserts every cycle, so overflow flagging is only meaningful with EDGE_MODE=1.
- any_pend: combinational OR of the registered D bits; no extra latency.
- Outputs are registered, except any_pend, which is combinational from registers.
- Multiple simultaneous events: all set independently in the same cycle. Priority resolution is the encoder's job.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles with req=4'b1111. After reset, D3..D0=0000 and ovf=0000. With EDGE_MODE=1 and mask=1111, D3..D0=1111 exactly SYNC_STAGES cycles after release. Holding req high produces no further events.
2. Single event: req=4'b0100 pulse of one cycle, mask=1111. After 2 edges, D2=1 and any_pend=1, others 0. ack_valid=1, ack_idx=2 for one cycle → D2=0, any_pend=0 next cycle.
3. Multiple events with priority ordering: req rises 4'b1010 simultaneously → D3=1, D1=1. Encoder-driven acks with idx=3 then idx=1 clear in that order. D3..D0 sequence is 1010 → 0010 → 0000.
4. Set/clear collision: while D0=1, a new rising edge on req[0] lands in the same cycle as ack idx=0. Required: D0 stays 1, ovf[0] stays 0. A further edge with no ack → ovf[0]=1. ovf_clr pulse → ovf=0000, D0 still 1.
5. Masking: mask=4'b1110 and req[0] rises → D0 stays 0. Unmask while req[0] still high → no event; D0 remains 0. Next fresh rising edge → D0=1.
6. Reset mid-operation and stray ack: D3..D0=1011 and ovf=0001, then one-cycle rst → all 0 next cycle. Ack idx=2 with D2=0 → no state change.
